// File: rtl/voter_case.sv
`default_nettype none
// ============================================================================
// Module      : voter_case
// Description : Four-member majority voter with a registered one-hot verdict.
//               Optional macro VOTER_TIEBREAK_EN lets the chairperson (I[3])
//               resolve a 2-2 split.
// Revision    : 1.0 - initial release
// ============================================================================
module voter_case #(
    parameter int PASS_THRESHOLD = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] I,
    output logic [2:0] O
);

    localparam logic [2:0] V_NONE    = 3'b000;
    localparam logic [2:0] V_PASS    = 3'b001;
    localparam logic [2:0] V_TIE     = 3'b010;
    localparam logic [2:0] V_FAIL    = 3'b100;
    localparam logic [2:0] THRESHOLD = 3'(PASS_THRESHOLD);
    localparam logic [2:0] TIE_COUNT = 3'd2;

    logic [2:0] yes_cnt;
    logic [2:0] verdict_next;

    always_comb begin
        yes_cnt = {2'b00, I[0]} + {2'b00, I[1]} + {2'b00, I[2]} + {2'b00, I[3]};
    end

    always_comb begin
        verdict_next = V_FAIL;
        if (yes_cnt >= THRESHOLD) begin
            verdict_next = V_PASS;
        end else if (yes_cnt == TIE_COUNT) begin
`ifdef VOTER_TIEBREAK_EN
            // Chairperson casts the deciding vote on an even split.
            verdict_next = I[3] ? V_PASS : V_FAIL;
`else
            verdict_next = V_TIE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O <= V_NONE;
        end else begin
            O <= verdict_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voter_case.sv
`default_nettype none
// ============================================================================
// Module      : tb_voter_case
// Description : Self-checking bench for voter_case (thresholds 3 and 4),
//               directed steps plus randomized ballots against a count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voter_case;

    logic       clk;
    logic       rst_n;
    logic [3:0] I;
    logic [2:0] O;
    logic [2:0] O4;

    int checks = 0;
    int errors = 0;

    voter_case #(.PASS_THRESHOLD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .O     (O)
    );

    voter_case #(.PASS_THRESHOLD(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .O     (O4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference verdict from the ballot rules: count yes votes, then decide.
    function automatic logic [2:0] model(input logic [3:0] b, input int th);
        int cnt;
        cnt = $countones(b);
        if (cnt >= th) return 3'b001;
        if (cnt == 2) begin
`ifdef VOTER_TIEBREAK_EN
            return b[3] ? 3'b001 : 3'b100;
`else
            return 3'b010;
`endif
        end
        return 3'b100;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive a ballot, let one edge sample it, then check both thresholds.
    task automatic step(input string tag, input logic [3:0] v);
        I = v;
        @(posedge clk);
        #1;
        chk(tag, O, model(v, 3));
        chk({tag, "_th4"}, O4, model(v, 4));
        chk({tag, "_onehot"}, {2'b00, $onehot(O)}, 3'b001);
    endtask

    initial begin
        rst_n = 1'b1;
        I     = 4'b1111;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async", O, 3'b000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", O, 3'b000);
            chk("reset_hold_th4", O4, 3'b000);
        end
        rst_n = 1'b1;
        step("first_verdict", 4'b1111);

        for (int v = 0; v < 16; v++) begin
            step("sweep", 4'(v));
        end

        step("th4_0111", 4'b0111);
        step("th4_1111", 4'b1111);
        step("tie_1100", 4'b1100);
        step("tie_0011", 4'b0011);
        step("zero", 4'b0000);

        // Asynchronous reset pulse between edges.
        step("pre_pulse", 4'b1111);
        #3 rst_n = 1'b0;
        #1;
        chk("pulse_clear", O, 3'b000);
        chk("pulse_clear_th4", O4, 3'b000);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pulse_restore", O, 3'b001);

        // Mid-cycle toggling: only the value present at the edge matters.
        I = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1 I = ~I;
            chk("no_glitch", O, 3'b001);
        end
        #1 I = 4'b0000;
        @(posedge clk);
        #1;
        chk("toggle_settle", O, 3'b100);

        for (int n = 0; n < 300; n++) begin
            step("random", 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
